mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline: receiving end of the 155-bit EXE→MEM bus, sending end of the 119-bit MEM→WB bus. Registers the EXE bus under a valid/allowin handshake and performs byte/word loads and stores over a variable-latency req/ack data-memory port. Produces the MEM→WB bus, the bypass destination and the displayed PC.

---
 rtl/cpu_bus_pkg.sv | 61 ++++++
 rtl/mem_stage_if.sv | 12 +
 rtl/mem_stage_align.sv | 25 ++
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared bus layouts for the EXE->MEM and MEM->WB pipeline buses,
// mem_control bit positions and the memory-stage FSM encoding.
package cpu_bus_pkg;

  localparam int EXE_MEM_W = 155;
  localparam int MEM_WB_W  = 119;

  // mem_control = {inst_load, inst_store, ls_word, lb_sign}
  localparam int MC_LOAD  = 3;
  localparam int MC_STORE = 2;
  localparam int MC_WORD  = 1;
  localparam int MC_SIGN  = 0;

  // Field order fixes the bit offsets: mem_control[154:151] down to pc[31:0].
  typedef struct packed {
    logic [3:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic        overflow;
    logic [31:0] pc;
  } exe_mem_t;

  // Field order fixes the bit offsets: rf_wen[118] down to pc[31:0].
  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        overflow;
    logic [31:0] pc;
  } mem_wb_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port. The stage is the master; the memory is the slave.
interface mem_stage_if;
  logic        dm_req;
  logic [3:0]  dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (output dm_req, dm_wen, dm_addr, dm_wdata, input dm_ack, dm_rdata);
  modport slave  (input dm_req, dm_wen, dm_addr, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane logic: store byte enables and lane replication, load byte
// extraction with sign/zero extension.
module mem_align (
  input  logic        ls_word,
  input  logic        lb_sign,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  store_wen,
  output logic [31:0] store_wdata,
  output logic [31:0] load_data
);

  logic [7:0] ld_byte;

  // Lane steering for both directions.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    store_wen   = ls_word ? 4'hF : (4'b0001 << byte_sel);
    store_wdata = ls_word ? store_data : {4{store_data[7:0]}};
    ld_byte     = 8'(rdata >> {byte_sel, 3'b000});
    load_data   = ls_word ? rdata : {{24{lb_sign & ld_byte[7]}}, ld_byte};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EXE bus under valid/allowin, runs the
// data-memory req/ack transaction and builds the MEM->WB bus.
module mem_stage
  import cpu_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EXE_over,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus,
  output logic                 MEM_allowin,
  input  logic                 WB_allowin,
  input  logic                 cancel,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  mem_stage_if.master          dm,
  output logic [4:0]           MEM_wdest,
  output logic [31:0]          MEM_pc
);

  exe_mem_t   bus_r;
  logic       mem_valid;
  logic [31:0] rdata_r;
  mem_state_e state, state_nxt;

  logic        is_load, is_store, is_mem, capture;
  logic        dm_req_c, rdata_en;
  logic [3:0]  store_wen;
  logic [31:0] store_wdata, load_data;
  mem_wb_t     wb;

  assign is_load  = bus_r.mem_control[MC_LOAD];
  assign is_store = bus_r.mem_control[MC_STORE];
  assign is_mem   = is_load | is_store;
  assign capture  = EXE_over & MEM_allowin;

  // Stage register: capture on handshake, drop on transfer or cancel.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      mem_valid <= 1'b0;
      // NOTE: the payload register is reset too, so MEM_WB_bus reads 0 out of reset.
      bus_r     <= '0;
    end else if (capture) begin
      mem_valid <= ~cancel;
      bus_r     <= exe_mem_t'(EXE_MEM_bus);
    end else if ((MEM_over & WB_allowin) | cancel) begin
      mem_valid <= 1'b0;
    end
  end

  // FSM state and load-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rdata_r <= '0;
    end else begin
      state <= state_nxt;
      if (rdata_en) rdata_r <= dm.dm_rdata;
    end
  end

  // Next state, request and handshake outputs.
  always_comb begin
    state_nxt = state;
    dm_req_c  = 1'b0;
    rdata_en  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_valid & is_mem & ~cancel) begin
          dm_req_c = 1'b1;
          if (dm.dm_ack) begin
            rdata_en  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        dm_req_c = 1'b1;
        if (dm.dm_ack) begin
          rdata_en  = 1'b1;
          state_nxt = cancel ? S_IDLE : S_DONE;
        end else if (cancel) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        if (WB_allowin | cancel) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        // A killed request stays up until the memory acknowledges it.
        dm_req_c = 1'b1;
        if (dm.dm_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    MEM_over    = mem_valid & (~is_mem | (state == S_DONE));
    MEM_allowin = (state != S_DRAIN) & (~mem_valid | (MEM_over & WB_allowin));
  end

  mem_align u_align (
    .ls_word     (bus_r.mem_control[MC_WORD]),
    .lb_sign     (bus_r.mem_control[MC_SIGN]),
    .byte_sel    (bus_r.exe_result[1:0]),
    .store_data  (bus_r.store_data),
    .rdata       (rdata_r),
    .store_wen   (store_wen),
    .store_wdata (store_wdata),
    .load_data   (load_data)
  );

  assign dm.dm_req   = dm_req_c;
  assign dm.dm_wen   = (dm_req_c & is_store) ? store_wen : 4'h0;
  assign dm.dm_addr  = {bus_r.exe_result[31:2], 2'b00};
  assign dm.dm_wdata = store_wdata;

  assign wb = '{
    rf_wen:     bus_r.rf_wen,
    rf_wdest:   bus_r.rf_wdest,
    mem_result: is_load ? load_data : bus_r.exe_result,
    lo_result:  bus_r.lo_result,
    hi_write:   bus_r.hi_write,
    lo_write:   bus_r.lo_write,
    mfhi:       bus_r.mfhi,
    mflo:       bus_r.mflo,
    mtc0:       bus_r.mtc0,
    mfc0:       bus_r.mfc0,
    cp0r_addr:  bus_r.cp0r_addr,
    syscall:    bus_r.syscall,
    eret:       bus_r.eret,
    overflow:   bus_r.overflow,
    pc:         bus_r.pc
  };

  assign MEM_WB_bus = wb;
  assign MEM_wdest  = bus_r.rf_wdest & {5{mem_valid}};
  assign MEM_pc     = bus_r.pc;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan cases with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         EXE_over, WB_allowin, cancel;
  logic [154:0] EXE_MEM_bus;
  logic         MEM_allowin, MEM_over;
  logic [118:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;
  logic [31:0]  MEM_pc;

  mem_stage_if dm();

  mem_stage u_dut (
    .clk         (clk),
    .reset       (reset),
    .EXE_over    (EXE_over),
    .EXE_MEM_bus (EXE_MEM_bus),
    .MEM_allowin (MEM_allowin),
    .WB_allowin  (WB_allowin),
    .cancel      (cancel),
    .MEM_over    (MEM_over),
    .MEM_WB_bus  (MEM_WB_bus),
    .dm          (dm),
    .MEM_wdest   (MEM_wdest),
    .MEM_pc      (MEM_pc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: the instruction held in MEM and what has happened to it.
  logic [154:0] m_inst;
  logic [31:0]  m_rdata;
  bit           m_valid, m_acked, m_req_open;

  // Memory responder.
  bit          r_active;
  int          r_cnt, r_delay;
  int          force_delay = -1;
  bit          fix_rdata   = 1'b0;
  logic [31:0] fixed_rdata = '0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {mem_control, store_data, exe_result, lo_result, hi_write..rf_wen, rf_wdest, overflow, pc}
  function automatic logic [154:0] make_bus(input logic [3:0] mc, input logic [31:0] sd,
      input logic [31:0] res, input logic [16:0] flags, input logic [4:0] wdest, input logic [31:0] pc);
    return {mc, sd, res, 32'h5A5A_0F0F, flags, wdest, 1'b0, pc};
  endfunction

  function automatic logic [154:0] rand_bus();
    logic [3:0] mc;
    case ($urandom_range(0, 6))
      0, 1:    mc = {2'b00, 2'($urandom)};
      2:       mc = 4'b0110;  // sw
      3:       mc = 4'b0100;  // sb
      4:       mc = 4'b1010;  // lw
      5:       mc = 4'b1001;  // lb
      default: mc = 4'b1000;  // lbu
    endcase
    return {mc, $urandom(), $urandom(), $urandom(), 17'($urandom), 5'($urandom), 1'($urandom), $urandom()};
  endfunction

  task automatic compare_and_update();
    logic [3:0]   mc;
    logic [31:0]  sd, res, mres, exp_wdata;
    logic [7:0]   byt;
    logic [3:0]   exp_wen;
    logic [118:0] exp_wb;
    logic         is_mem, exp_over, exp_req, exp_allowin;
    mc     = m_inst[154:151];
    sd     = m_inst[150:119];
    res    = m_inst[118:87];
    is_mem = mc[3] | mc[2];

    byt  = 8'(m_rdata >> (8 * res[1:0]));
    mres = !mc[3] ? res : (mc[1] ? m_rdata : {{24{mc[0] & byt[7]}}, byt});
    exp_wb = {m_inst[38], m_inst[37:33], mres, m_inst[86:55], m_inst[54:39], m_inst[32], m_inst[31:0]};
    exp_wen   = mc[1] ? 4'hF : 4'(4'b0001 << res[1:0]);
    exp_wdata = mc[1] ? sd : {4{sd[7:0]}};

    exp_over    = m_valid && (!is_mem || m_acked);
    exp_req     = m_req_open || (m_valid && is_mem && !m_acked && !cancel);
    exp_allowin = !m_req_open && (!m_valid || (exp_over && WB_allowin));

    check("MEM_over", MEM_over, exp_over);
    check("dm_req", dm.dm_req, exp_req);
    check("MEM_allowin", MEM_allowin, exp_allowin);
    check("MEM_wdest", MEM_wdest, m_valid ? m_inst[37:33] : 5'd0);
    check("MEM_pc", MEM_pc, m_inst[31:0]);
    if (exp_over) check("MEM_WB_bus", MEM_WB_bus, exp_wb);
    if (exp_req) begin
      check("dm_addr", dm.dm_addr, {res[31:2], 2'b00});
      check("dm_wen", dm.dm_wen, mc[2] ? exp_wen : 4'h0);
      if (mc[2]) check("dm_wdata", dm.dm_wdata, exp_wdata);
    end

    // Advance the model across the coming clock edge.
    if (dm.dm_ack) begin
      m_req_open = 1'b0;
      if (m_valid && is_mem && !m_acked && !cancel) begin
        m_acked = 1'b1;
        m_rdata = dm.dm_rdata;
      end
    end else if (exp_req) begin
      m_req_open = 1'b1;
    end
    if ((exp_over && WB_allowin) || cancel) m_valid = 1'b0;
    if (EXE_over && exp_allowin) begin
      m_inst  = EXE_MEM_bus;
      m_valid = !cancel;
      m_acked = 1'b0;
    end

    if (dm.dm_req && dm.dm_ack) r_active = 1'b0;
    else if (dm.dm_req)         r_cnt++;
    else                        r_active = 1'b0;
  endtask

  task automatic cycle(input logic eo, input logic [154:0] b, input logic wa, input logic cn);
    @(negedge clk);
    EXE_over    = eo;
    EXE_MEM_bus = b;
    WB_allowin  = wa;
    cancel      = cn;
    dm.dm_rdata = fix_rdata ? fixed_rdata : $urandom();
    dm.dm_ack   = 1'b0;
    #1;
    if (dm.dm_req) begin
      if (!r_active) begin
        r_active = 1'b1;
        r_cnt    = 0;
        r_delay  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
      end
      dm.dm_ack = (r_cnt == r_delay);
    end
    #1;
    compare_and_update();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    EXE_over    = 1'b0;
    WB_allowin  = 1'b0;
    cancel      = 1'b0;
    EXE_MEM_bus = '0;
    dm.dm_ack   = 1'b0;
    dm.dm_rdata = '0;
    m_inst = '0; m_rdata = '0; m_valid = 0; m_acked = 0; m_req_open = 0;
    r_active = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_MEM_over", MEM_over, 1'b0);
    check("rst_MEM_allowin", MEM_allowin, 1'b1);
    check("rst_dm_req", dm.dm_req, 1'b0);
    check("rst_MEM_wdest", MEM_wdest, 5'd0);
    check("rst_MEM_pc", MEM_pc, 32'd0);
    check("rst_MEM_WB_bus", MEM_WB_bus, 119'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [154:0] b;
    do_reset();

    // addu pass-through.
    b = make_bus(4'b0000, 32'h0, 32'h0000_1234, 17'h00001, 5'd5, 32'hBFC0_0010);
    cycle(1'b1, b, 1'b1, 1'b0);
    cycle(1'b0, rand_bus(), 1'b1, 1'b0);
    check("addu_over", MEM_over, 1'b1);
    check("addu_result", MEM_WB_bus[112:81], 32'h0000_1234);
    check("addu_wdest", MEM_wdest, 5'd5);

    // sb with same-cycle ack.
    force_delay = 0;
    b = make_bus(4'b0100, 32'h0000_00AB, 32'h0000_1003, 17'h0, 5'd0, 32'hBFC0_0014);
    cycle(1'b1, b, 1'b1, 1'b0);
    cycle(1'b0, rand_bus(), 1'b1, 1'b0);
    check("sb_req", dm.dm_req, 1'b1);
    check("sb_addr", dm.dm_addr, 32'h0000_1000);
    check("sb_wen", dm.dm_wen, 4'b1000);
    check("sb_wdata", dm.dm_wdata, 32'hABAB_ABAB);
    cycle(1'b0, rand_bus(), 1'b1, 1'b0);
    check("sb_over", MEM_over, 1'b1);

    // lb signed then unsigned, ack in the third request cycle.
    force_delay = 2;
    fix_rdata   = 1'b1;
    fixed_rdata = 32'h80FF_0000;
    for (int k = 0; k < 2; k++) begin
      b = make_bus(k == 0 ? 4'b1001 : 4'b1000, 32'h0, 32'h0000_2003, 17'h00001, 5'd9, 32'hBFC0_0020);
      cycle(1'b1, b, 1'b1, 1'b0);
      for (int j = 0; j < 3; j++) begin
        cycle(1'b0, rand_bus(), 1'b1, 1'b0);
        check("lb_req_held", dm.dm_req, 1'b1);
        check("lb_addr", dm.dm_addr, 32'h0000_2000);
      end
      cycle(1'b0, rand_bus(), 1'b1, 1'b0);
      check("lb_over", MEM_over, 1'b1);
      check("lb_result", MEM_WB_bus[112:81], k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
    end
    fix_rdata = 1'b0;

    // lw back-pressure: result held, no second request.
    force_delay = 1;
    b = make_bus(4'b1010, 32'h0, 32'h0000_3000, 17'h00001, 5'd3, 32'hBFC0_0030);
    cycle(1'b1, b, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) cycle(1'b1, rand_bus(), 1'b0, 1'b0);
    check("bp_over", MEM_over, 1'b1);
    check("bp_allowin", MEM_allowin, 1'b0);
    check("bp_req", dm.dm_req, 1'b0);
    cycle(1'b0, rand_bus(), 1'b1, 1'b0);

    // Cancel while waiting: request drained, nothing delivered.
    force_delay = 3;
    b = make_bus(4'b1010, 32'h0, 32'h0000_4000, 17'h00001, 5'd7, 32'hBFC0_0040);
    cycle(1'b1, b, 1'b1, 1'b0);
    cycle(1'b0, rand_bus(), 1'b1, 1'b0);
    cycle(1'b1, rand_bus(), 1'b1, 1'b1);
    cycle(1'b1, rand_bus(), 1'b1, 1'b0);
    check("drain_wdest", MEM_wdest, 5'd0);
    check("drain_req", dm.dm_req, 1'b1);
    check("drain_allowin", MEM_allowin, 1'b0);
    check("drain_over", MEM_over, 1'b0);
    cycle(1'b1, rand_bus(), 1'b1, 1'b0);
    cycle(1'b0, rand_bus(), 1'b1, 1'b0);
    check("drain_done_allowin", MEM_allowin, 1'b1);

    // Randomized traffic.
    force_delay = -1;
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 9) < 7, rand_bus(), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    // Asynchronous reset in the middle of a waiting request.
    do_reset();
    force_delay = 10;
    b = make_bus(4'b1010, 32'h0, 32'h0000_5000, 17'h00001, 5'd4, 32'hBFC0_0050);
    cycle(1'b1, b, 1'b1, 1'b0);
    cycle(1'b0, rand_bus(), 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("pre_reset_req", dm.dm_req, 1'b1);
    check("pre_reset_wdest", MEM_wdest, 5'd4);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_req", dm.dm_req, 1'b0);
    check("async_rst_over", MEM_over, 1'b0);
    check("async_rst_allowin", MEM_allowin, 1'b1);
    check("async_rst_wdest", MEM_wdest, 5'd0);
    check("async_rst_pc", MEM_pc, 32'd0);
    check("async_rst_bus", MEM_WB_bus, 119'd0);
    do_reset();
    force_delay = -1;
    for (int n = 0; n < 200; n++)
      cycle($urandom_range(0, 1) == 1, rand_bus(), $urandom_range(0, 3) != 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
